// File: rtl/nibble_alu_pkg.sv
// Shared encodings for the nibble-serial ALU: slice op codes, sequencer states, nibble width.
package nibble_alu_pkg;

   localparam int NIB_W = 4;

   localparam logic [1:0] OP_PASS = 2'b00;
   localparam logic [1:0] OP_INV  = 2'b01;
   localparam logic [1:0] OP_ZERO = 2'b10;
   localparam logic [1:0] OP_ONES = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/nibble_slice.sv
// One 4-bit operand-select + adder slice; purely combinational, zero latency, no flow control.
module nibble_slice
   import nibble_alu_pkg::*;
(
   input  logic [NIB_W-1:0] a_i,
   input  logic [NIB_W-1:0] b_i,
   input  logic [1:0]       op_i,
   input  logic             cin_i,
   output logic [NIB_W-1:0] sum_o,
   output logic             cout_o,
   output logic             c3_o
);

   logic [NIB_W-1:0] y;

   always_comb begin
      y = b_i;
      case (op_i)
         OP_PASS: y = b_i;
         OP_INV:  y = ~b_i;
         OP_ZERO: y = '0;
         OP_ONES: y = '1;
         default: y = b_i;
      endcase
   end

   assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, y} + {{NIB_W{1'b0}}, cin_i};
   // Carry into the MSB falls out of the MSB sum bit and its two addends.
   assign c3_o = a_i[NIB_W-1] ^ y[NIB_W-1] ^ sum_o[NIB_W-1];

endmodule

// File: rtl/nibble_serial_alu_seq.sv
// Nibble-serial ADD/SUB/INC/DEC sequencer, LSB nibble first; result valid NIBBLES edges after accept.
// Holds DONE and the result while out_ready is low; optional zero/ovf flags under NIBBLE_SERIAL_ALU_FLAGS_EN.
module nibble_serial_alu_seq
   import nibble_alu_pkg::*;
#(
   parameter int NIBBLES = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [NIB_W*NIBBLES-1:0] a_i,
   input  logic [NIB_W*NIBBLES-1:0] b_i,
   input  logic [1:0]               op_i,
   input  logic                     cin_i,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [NIB_W*NIBBLES-1:0] d_o,
   output logic                     cout_o
`ifdef NIBBLE_SERIAL_ALU_FLAGS_EN
   ,
   output logic                     zero_o,
   output logic                     ovf_o
`endif
);

   localparam int WIDTH = NIB_W * NIBBLES;
   localparam int IDX_W = $clog2(NIBBLES) + 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [1:0]       op_q, op_d;
   logic             carry_q, carry_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [WIDTH-1:0] dq_q, dq_d;
   logic             cout_q, cout_d;

   logic [NIB_W-1:0] a_nib, b_nib, s_sum;
   logic             s_cout;

`ifdef NIBBLE_SERIAL_ALU_FLAGS_EN
   logic s_c3;
   logic zero_q, zero_d;
   logic ovf_q, ovf_d;
`else
   logic unused_c3;
`endif

   always_comb begin
      a_nib = '0;
      b_nib = '0;
      for (int i = 0; i < NIBBLES; i++) begin
         if (idx_q == IDX_W'(i)) begin
            a_nib = a_q[i*NIB_W +: NIB_W];
            b_nib = b_q[i*NIB_W +: NIB_W];
         end
      end
   end

   nibble_slice u_slice (
      .a_i    (a_nib),
      .b_i    (b_nib),
      .op_i   (op_q),
      .cin_i  (carry_q),
      .sum_o  (s_sum),
      .cout_o (s_cout),
`ifdef NIBBLE_SERIAL_ALU_FLAGS_EN
      .c3_o   (s_c3)
`else
      .c3_o   (unused_c3)
`endif
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         carry_q <= 1'b0;
         idx_q   <= '0;
         dq_q    <= '0;
         cout_q  <= 1'b0;
`ifdef NIBBLE_SERIAL_ALU_FLAGS_EN
         zero_q  <= 1'b0;
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         carry_q <= carry_d;
         idx_q   <= idx_d;
         dq_q    <= dq_d;
         cout_q  <= cout_d;
`ifdef NIBBLE_SERIAL_ALU_FLAGS_EN
         zero_q  <= zero_d;
         ovf_q   <= ovf_d;
`endif
      end
   end

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      op_d      = op_q;
      carry_d   = carry_q;
      idx_d     = idx_q;
      dq_d      = dq_q;
      cout_d    = cout_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
`ifdef NIBBLE_SERIAL_ALU_FLAGS_EN
      zero_d    = zero_q;
      ovf_d     = ovf_q;
`endif
      case (state_q)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               a_d     = a_i;
               b_d     = b_i;
               op_d    = op_i;
               carry_d = cin_i;
               idx_d   = '0;
               dq_d    = '0;
`ifdef NIBBLE_SERIAL_ALU_FLAGS_EN
               zero_d  = 1'b0;
               ovf_d   = 1'b0;
`endif
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            for (int i = 0; i < NIBBLES; i++) begin
               if (idx_q == IDX_W'(i)) dq_d[i*NIB_W +: NIB_W] = s_sum;
            end
            carry_d = s_cout;
            idx_d   = idx_q + IDX_W'(1);
            if (idx_q == IDX_LAST) begin
               cout_d  = s_cout;
`ifdef NIBBLE_SERIAL_ALU_FLAGS_EN
               zero_d  = (dq_d == '0);
               ovf_d   = s_c3 ^ s_cout;
`endif
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign d_o    = dq_q;
   assign cout_o = cout_q;
`ifdef NIBBLE_SERIAL_ALU_FLAGS_EN
   assign zero_o = zero_q;
   assign ovf_o  = ovf_q;
`endif

endmodule
